udp_tx_packetizer: RTL and testbench
====================================

// Module: udp_tx_packetizer
// PURPOSE
//   Builds outbound UDP datagrams from the user nibble command interface and drives the
//   s_udp_* header and payload inputs of udp_complete. Each accepted beat becomes one
//   payload byte {in_command, in_data}. Bytes are buffered up to MAX_PAYLOAD, or until
//   FLUSH_TIMEOUT idle cycles, and are then sent to the current peer (last remote IP/port).
// PARAMETERS
//   MAX_PAYLOAD    1    payload bytes per datagram (1..64); a full buffer triggers a send
//   FLUSH_TIMEOUT  0    idle cycles before a partial buffer is sent; 0 = never flush
//   IP_TTL         64   value driven on m_udp_ip_ttl
// PORTS
//   clk                     in   1   125 MHz logic clock
//   rst                     in   1   synchronous, active-high reset
//   in_valid                in   1   user beat valid (tx_ready)
//   in_ready                out  1   block can accept a beat
//   in_command              in   4   upper payload nibble
//   in_data                 in   4   lower payload nibble
//   peer_valid              in   1   peer_ip/peer_port hold a known destination
//   peer_ip                 in   32  destination IP (rx_udp_ip_source_ip)
//   peer_port               in   16  destination UDP port
//   local_ip                in   32  source IP
//   local_port              in   16  source UDP port
//   m_udp_hdr_valid         out  1   header valid to udp_complete
//   m_udp_hdr_ready         in   1   header accepted
//   m_udp_ip_dscp/ecn       out  6/2 constant 0
//   m_udp_ip_ttl            out  8   IP_TTL
//   m_udp_ip_source_ip      out  32  latched local_ip
//   m_udp_ip_dest_ip        out  32  latched peer_ip
//   m_udp_source_port       out  16  latched local_port
//   m_udp_dest_port         out  16  latched peer_port
//   m_udp_length            out  16  8 + byte count
//   m_udp_checksum          out  16  constant 0 (no checksum)
//   m_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  8/out,1/out,1/in,1/out,1/out
//   drop_count              out  16  datagrams discarded for no peer (saturates at 0xFFFF)
//   busy                    out  1   state != FILL
// BEHAVIOUR
//   States: FILL -> HDR -> PAYLOAD -> FILL. All outputs are registered except in_ready.
//   in_ready = (state==FILL) && !rst.
//   Reset: state=FILL, cnt=0, idx=0, idle=0, hdr_valid=0, tvalid=0, tlast=0, tdata=0,
//     tuser=0, all header fields 0, drop_count=0, busy=0.
//   FILL: on in_valid&&in_ready, write buf[cnt] = {in_command,in_data}, cnt++, idle=0.
//     While cnt>0 with no beat, idle++ (saturating). Send condition: cnt reaches MAX_PAYLOAD,
//     or FLUSH_TIMEOUT!=0 && cnt>0 && idle==FLUSH_TIMEOUT-1 with no beat this cycle.
//     A beat arriving in the timeout cycle is taken and resets idle instead of flushing.
//   On send, if peer_valid=1: latch header fields, m_udp_length = 16'd8 + cnt
//     (zero-extended), hdr_valid<=1, state=HDR. If peer_valid=0: discard, cnt=0, idle=0,
//     drop_count++ (saturating), stay in FILL.
//   Latency: the last byte is accepted in cycle N; hdr_valid is high in cycle N+1.
//   HDR: hdr_valid and header fields stay stable until m_udp_hdr_ready. On the handshake,
//     hdr_valid<=0, tvalid<=1, tdata<=buf[0], tlast<=(cnt==1), idx=0, state=PAYLOAD.
//   PAYLOAD: tdata, tvalid and tlast stay stable while tready=0. On the handshake, idx++ and
//     the next byte is presented; tlast is high only for byte idx==cnt-1.
//     The tlast handshake drives tvalid<=0, cnt=0, idle=0, state=FILL. There is no
//     back-to-back overlap: in_ready stays low from the send decision to the tlast beat.
//   Header and payload are never valid in the same cycle. tuser is always 0.
//   Peer inputs that change after the header latch do not affect an in-flight datagram.
//   cnt and idx are $clog2(MAX_PAYLOAD+1) bits wide; cnt is never 0 in HDR or PAYLOAD.
//   rst in any state aborts immediately; the partial buffer is lost and the next cycle
//     shows reset values. udp_complete shares rst, so no truncated frame is left downstream.
// TESTING
//   1. MAX_PAYLOAD=1, peer 10.42.0.1:5000, local 10.42.0.164:8887; beat cmd=4'hA data=4'h5
//      -> hdr_valid the next cycle, length=9, dest_ip=0x0A2A0001, dest_port=5000; then one
//      beat 0xA5 with tlast=1.
//   2. MAX_PAYLOAD=4, beats 0x11,0x22,0x33,0x44 with random tready -> one datagram,
//      length=12, bytes in order, tlast only on 0x44, data stable while stalled.
//   3. MAX_PAYLOAD=8, FLUSH_TIMEOUT=16; 3 beats then idle -> send decided 16 cycles after
//      the last beat, length=11; a beat at idle=14 restarts the count.
//   4. peer_valid=0, MAX_PAYLOAD=1, 3 beats -> no hdr_valid, drop_count=3, in_ready stays 1.
//   5. hdr_ready held low for 50 cycles -> header stable, in_ready=0, later beats held off;
//      peer_ip changed mid-hold -> the emitted dest_ip is still the latched value.
//   6. rst asserted mid-PAYLOAD (idx=2 of 4) -> next cycle tvalid=0, hdr_valid=0, in_ready=0;
//      after rst deasserts, in_ready=1, cnt=0, and a fresh datagram sends correctly.

Source files
------------

// File: rtl/udp_tx_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_packetizer_if
// Description : UDP header and payload bus between the packetizer and
//               udp_complete.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_tx_packetizer_if;
    logic        m_udp_hdr_valid;
    logic        m_udp_hdr_ready;
    logic [5:0]  m_udp_ip_dscp;
    logic [1:0]  m_udp_ip_ecn;
    logic [7:0]  m_udp_ip_ttl;
    logic [31:0] m_udp_ip_source_ip;
    logic [31:0] m_udp_ip_dest_ip;
    logic [15:0] m_udp_source_port;
    logic [15:0] m_udp_dest_port;
    logic [15:0] m_udp_length;
    logic [15:0] m_udp_checksum;
    logic [7:0]  m_udp_payload_axis_tdata;
    logic        m_udp_payload_axis_tvalid;
    logic        m_udp_payload_axis_tready;
    logic        m_udp_payload_axis_tlast;
    logic        m_udp_payload_axis_tuser;

    modport master (
        output m_udp_hdr_valid, m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl,
               m_udp_ip_source_ip, m_udp_ip_dest_ip, m_udp_source_port,
               m_udp_dest_port, m_udp_length, m_udp_checksum,
               m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
               m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
        input  m_udp_hdr_ready, m_udp_payload_axis_tready
    );

    modport slave (
        input  m_udp_hdr_valid, m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl,
               m_udp_ip_source_ip, m_udp_ip_dest_ip, m_udp_source_port,
               m_udp_dest_port, m_udp_length, m_udp_checksum,
               m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
               m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
        output m_udp_hdr_ready, m_udp_payload_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/udp_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_packetizer
// Description : Packs nibble command beats into UDP datagrams sent to the
//               current peer, flushing on a full buffer or an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_packetizer #(
    parameter int MAX_PAYLOAD   = 1,
    parameter int FLUSH_TIMEOUT = 0,
    parameter int IP_TTL        = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_command,
    input  logic [3:0]           in_data,
    input  logic                 peer_valid,
    input  logic [31:0]          peer_ip,
    input  logic [15:0]          peer_port,
    input  logic [31:0]          local_ip,
    input  logic [15:0]          local_port,
    udp_tx_packetizer_if.master  m_udp,
    output logic [15:0]          drop_count,
    output logic                 busy
);

    localparam int c_CNT_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int c_ADDR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int c_DEPTH  = 1 << c_ADDR_W;
    localparam int c_IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX   = c_CNT_W'(MAX_PAYLOAD);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
        c_IDLE_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
    localparam logic                c_FLUSH_EN  = (FLUSH_TIMEOUT != 0);
    localparam logic [c_ADDR_W-1:0] c_ADDR_ZERO = '0;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_idx;
    logic [c_IDLE_W-1:0]  r_idle;
    logic [7:0]           r_buf [0:c_DEPTH-1];

    logic                 r_hdr_valid;
    logic [31:0]          r_src_ip;
    logic [31:0]          r_dst_ip;
    logic [15:0]          r_src_port;
    logic [15:0]          r_dst_port;
    logic [15:0]          r_length;
    logic [7:0]           r_tdata;
    logic                 r_tvalid;
    logic                 r_tlast;
    logic [15:0]          r_drop_count;
    logic                 r_busy;

    logic                 w_beat;
    logic                 w_send;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic [c_CNT_W-1:0]   w_send_cnt;
    logic [c_CNT_W-1:0]   w_idx_inc;
    logic [c_CNT_W-1:0]   w_cnt_last;
    logic                 w_hdr_hs;
    logic                 w_pay_hs;

    assign in_ready = (r_state == S_FILL) && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_send      = 1'b0;
        w_cnt_inc   = r_cnt + c_CNT_ONE;
        w_send_cnt  = r_cnt;
        w_idx_inc   = r_idx + c_CNT_ONE;
        w_cnt_last  = r_cnt - c_CNT_ONE;
        w_hdr_hs    = r_hdr_valid && m_udp.m_udp_hdr_ready;
        w_pay_hs    = r_tvalid && m_udp.m_udp_payload_axis_tready;
        case (r_state)
            S_FILL: begin
                w_beat = in_valid && in_ready;
                // A beat in the timeout cycle wins over the flush.
                if (w_beat && (w_cnt_inc == c_CNT_MAX)) begin
                    w_send     = 1'b1;
                    w_send_cnt = w_cnt_inc;
                end else if (!w_beat && c_FLUSH_EN && (r_cnt != '0) &&
                             (r_idle == c_IDLE_LAST)) begin
                    w_send = 1'b1;
                end
                if (w_send && peer_valid) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_hdr_hs) begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_pay_hs && r_tlast) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload storage carries no reset; cnt alone defines which bytes are live.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_buf[r_cnt[c_ADDR_W-1:0]] <= {in_command, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_idle       <= '0;
            r_hdr_valid  <= 1'b0;
            r_src_ip     <= '0;
            r_dst_ip     <= '0;
            r_src_port   <= '0;
            r_dst_port   <= '0;
            r_length     <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_drop_count <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_FILL);
            case (r_state)
                S_FILL: begin
                    if (w_beat) begin
                        r_cnt  <= w_cnt_inc;
                        r_idle <= '0;
                    end else if ((r_cnt != '0) && (r_idle != '1)) begin
                        r_idle <= r_idle + c_IDLE_ONE;
                    end
                    if (w_send) begin
                        if (peer_valid) begin
                            r_src_ip    <= local_ip;
                            r_dst_ip    <= peer_ip;
                            r_src_port  <= local_port;
                            r_dst_port  <= peer_port;
                            r_length    <= 16'd8 + 16'(w_send_cnt);
                            r_hdr_valid <= 1'b1;
                        end else begin
                            r_cnt  <= '0;
                            r_idle <= '0;
                            if (r_drop_count != 16'hFFFF) begin
                                r_drop_count <= r_drop_count + 16'd1;
                            end
                        end
                    end
                end
                S_HDR: begin
                    if (w_hdr_hs) begin
                        r_hdr_valid <= 1'b0;
                        r_tvalid    <= 1'b1;
                        r_tdata     <= r_buf[c_ADDR_ZERO];
                        r_tlast     <= (r_cnt == c_CNT_ONE);
                        r_idx       <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pay_hs) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_cnt    <= '0;
                            r_idle   <= '0;
                            r_idx    <= '0;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_tdata <= r_buf[w_idx_inc[c_ADDR_W-1:0]];
                            r_tlast <= (w_idx_inc == w_cnt_last);
                        end
                    end
                end
                default: begin
                    r_hdr_valid <= 1'b0;
                    r_tvalid    <= 1'b0;
                end
            endcase
        end
    end

    assign m_udp.m_udp_hdr_valid           = r_hdr_valid;
    assign m_udp.m_udp_ip_dscp             = 6'd0;
    assign m_udp.m_udp_ip_ecn              = 2'd0;
    assign m_udp.m_udp_ip_ttl              = 8'(IP_TTL);
    assign m_udp.m_udp_ip_source_ip        = r_src_ip;
    assign m_udp.m_udp_ip_dest_ip          = r_dst_ip;
    assign m_udp.m_udp_source_port         = r_src_port;
    assign m_udp.m_udp_dest_port           = r_dst_port;
    assign m_udp.m_udp_length              = r_length;
    assign m_udp.m_udp_checksum            = 16'd0;
    assign m_udp.m_udp_payload_axis_tdata  = r_tdata;
    assign m_udp.m_udp_payload_axis_tvalid = r_tvalid;
    assign m_udp.m_udp_payload_axis_tlast  = r_tlast;
    assign m_udp.m_udp_payload_axis_tuser  = 1'b0;
    assign drop_count                      = r_drop_count;
    assign busy                            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_packetizer
// Description : Scoreboard bench for udp_tx_packetizer in three payload
//               configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd, dat;
    logic        peer_valid;
    logic [31:0] peer_ip, local_ip;
    logic [15:0] peer_port, local_port;
    logic        v1, v4, v8;
    logic        r1, r4, r8;
    logic [15:0] drop1, drop4, drop8;
    logic        busy1, busy4, busy8;

    logic [7:0]  q1[$], q4[$], q8[$];
    logic [7:0]  exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    udp_tx_packetizer_if if1();
    udp_tx_packetizer_if if4();
    udp_tx_packetizer_if if8();

    always #4 clk = ~clk;

    udp_tx_packetizer #(.MAX_PAYLOAD(1), .FLUSH_TIMEOUT(0), .IP_TTL(64)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_command(cmd), .in_data(dat),
        .peer_valid(peer_valid), .peer_ip(peer_ip), .peer_port(peer_port),
        .local_ip(local_ip), .local_port(local_port), .m_udp(if1),
        .drop_count(drop1), .busy(busy1));

    udp_tx_packetizer #(.MAX_PAYLOAD(4), .FLUSH_TIMEOUT(0), .IP_TTL(64)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_command(cmd), .in_data(dat),
        .peer_valid(peer_valid), .peer_ip(peer_ip), .peer_port(peer_port),
        .local_ip(local_ip), .local_port(local_port), .m_udp(if4),
        .drop_count(drop4), .busy(busy4));

    udp_tx_packetizer #(.MAX_PAYLOAD(8), .FLUSH_TIMEOUT(16), .IP_TTL(64)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_command(cmd), .in_data(dat),
        .peer_valid(peer_valid), .peer_ip(peer_ip), .peer_port(peer_port),
        .local_ip(local_ip), .local_port(local_port), .m_udp(if8),
        .drop_count(drop8), .busy(busy8));

    // Drives one beat into the chosen DUT and records it if it will be sent.
    task automatic beat(input int d, input logic [7:0] b);
        cmd = b[7:4];
        dat = b[3:0];
        case (d)
            1:       v1 = 1'b1;
            4:       v4 = 1'b1;
            default: v8 = 1'b1;
        endcase
        if (peer_valid) begin
            case (d)
                1:       q1.push_back(b);
                4:       q4.push_back(b);
                default: q8.push_back(b);
            endcase
        end
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({if1.m_udp_hdr_valid, if4.m_udp_hdr_valid, if8.m_udp_hdr_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_hdr_valid: got %b want 000", {if1.m_udp_hdr_valid, if4.m_udp_hdr_valid, if8.m_udp_hdr_valid}); end
        n_checks++; if ({if1.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tvalid, if8.m_udp_payload_axis_tvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_tvalid: got %b want 000", {if1.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tvalid, if8.m_udp_payload_axis_tvalid}); end
        n_checks++; if ({if4.m_udp_payload_axis_tlast, if4.m_udp_payload_axis_tdata, if4.m_udp_payload_axis_tuser} !== 10'd0) begin n_fail++; $display("FAIL reset_tdata_tlast: got %h want 0", {if4.m_udp_payload_axis_tlast, if4.m_udp_payload_axis_tdata}); end
        n_checks++; if ({if4.m_udp_length, if4.m_udp_ip_dest_ip, if4.m_udp_dest_port, if4.m_udp_ip_source_ip, if4.m_udp_source_port} !== 112'd0) begin n_fail++; $display("FAIL reset_header_fields: got len %h ip %h want 0", if4.m_udp_length, if4.m_udp_ip_dest_ip); end
        n_checks++; if ({drop1, drop4, drop8} !== 48'd0) begin n_fail++; $display("FAIL reset_drop_count: got %h want 0", {drop1, drop4, drop8}); end
        n_checks++; if ({busy1, busy4, busy8} !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b want 000", {busy1, busy4, busy8}); end
        n_checks++; if ({r1, r4, r8} !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready_in_rst: got %b want 000", {r1, r4, r8}); end
        rst = 1'b0;
        #1;
        n_checks++; if ({r1, r4, r8} !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 111", {r1, r4, r8}); end
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        beat(1, 8'hA5);
        n_checks++; if (if1.m_udp_hdr_valid !== 1'b1) begin n_fail++; $display("FAIL single_hdr_latency: got %b want 1", if1.m_udp_hdr_valid); end
        n_checks++; if (if1.m_udp_length !== 16'd9) begin n_fail++; $display("FAIL single_length: got %0d want 9", if1.m_udp_length); end
        n_checks++; if ({if1.m_udp_ip_dest_ip, if1.m_udp_dest_port} !== {32'h0A2A0001, 16'd5000}) begin n_fail++; $display("FAIL single_dest: got %h:%0d want 0a2a0001:5000", if1.m_udp_ip_dest_ip, if1.m_udp_dest_port); end
        n_checks++; if ({if1.m_udp_ip_source_ip, if1.m_udp_source_port} !== {32'h0A2A00A4, 16'd8887}) begin n_fail++; $display("FAIL single_source: got %h:%0d want 0a2a00a4:8887", if1.m_udp_ip_source_ip, if1.m_udp_source_port); end
        n_checks++; if ({if1.m_udp_ip_ttl, if1.m_udp_ip_dscp, if1.m_udp_ip_ecn, if1.m_udp_checksum} !== {8'd64, 6'd0, 2'd0, 16'd0}) begin n_fail++; $display("FAIL single_constants: got ttl %0d csum %h want 64 0", if1.m_udp_ip_ttl, if1.m_udp_checksum); end
        n_checks++; if ({r1, busy1, if1.m_udp_payload_axis_tvalid} !== 3'b010) begin n_fail++; $display("FAIL single_hdr_state: got ready/busy/tvalid %b want 010", {r1, busy1, if1.m_udp_payload_axis_tvalid}); end
        if1.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if1.m_udp_hdr_ready = 1'b0;
        exp = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        n_checks++; if ({if1.m_udp_hdr_valid, if1.m_udp_payload_axis_tvalid, if1.m_udp_payload_axis_tlast, if1.m_udp_payload_axis_tdata} !== {3'b011, exp}) begin n_fail++; $display("FAIL single_payload: got hv/tv/tl %b data %h want 011 %h", {if1.m_udp_hdr_valid, if1.m_udp_payload_axis_tvalid, if1.m_udp_payload_axis_tlast}, if1.m_udp_payload_axis_tdata, exp); end
        if1.m_udp_payload_axis_tready = 1'b1;
        @(negedge clk);
        if1.m_udp_payload_axis_tready = 1'b0;
        n_checks++; if ({if1.m_udp_payload_axis_tvalid, r1, busy1} !== 3'b010) begin n_fail++; $display("FAIL single_done: got tv/ready/busy %b want 010", {if1.m_udp_payload_axis_tvalid, r1, busy1}); end
    endtask

    task automatic test_no_peer;
        peer_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL nopeer_in_ready: got %b want 1", r1); end
            beat(1, 8'(8'h30 + i));
            n_checks++; if (if1.m_udp_hdr_valid !== 1'b0) begin n_fail++; $display("FAIL nopeer_hdr_valid: got %b want 0", if1.m_udp_hdr_valid); end
        end
        n_checks++; if (drop1 !== 16'd3) begin n_fail++; $display("FAIL nopeer_drop_count: got %0d want 3", drop1); end
        n_checks++; if ({r1, busy1} !== 2'b10) begin n_fail++; $display("FAIL nopeer_idle: got ready/busy %b want 10", {r1, busy1}); end
        peer_valid = 1'b1;
    endtask

    task automatic test_random_tready;
        logic       prev_stall = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        logic       done = 1'b0;
        beat(4, 8'h11); beat(4, 8'h22); beat(4, 8'h33); beat(4, 8'h44);
        n_checks++; if ({if4.m_udp_hdr_valid, if4.m_udp_length} !== {1'b1, 16'd12}) begin n_fail++; $display("FAIL burst_header: got hv %b len %0d want 1 12", if4.m_udp_hdr_valid, if4.m_udp_length); end
        if4.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if4.m_udp_hdr_ready = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            n_checks++; if (if4.m_udp_hdr_valid && if4.m_udp_payload_axis_tvalid) begin n_fail++; $display("FAIL burst_hdr_payload_overlap: got both valid want exclusive"); end
            if (prev_stall) begin
                n_checks++; if ({if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast, if4.m_udp_payload_axis_tdata} !== {1'b1, pl, pd}) begin n_fail++; $display("FAIL burst_stall_stable: got tv/tl %b data %h want 1%b %h", {if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast}, if4.m_udp_payload_axis_tdata, pl, pd); end
            end
            if4.m_udp_payload_axis_tready = 1'($urandom_range(0, 1));
            if (if4.m_udp_payload_axis_tvalid && if4.m_udp_payload_axis_tready) begin
                exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
                n_checks++; if (if4.m_udp_payload_axis_tdata !== exp) begin n_fail++; $display("FAIL burst_byte: got %h want %h", if4.m_udp_payload_axis_tdata, exp); end
                n_checks++; if (if4.m_udp_payload_axis_tlast !== 1'(q4.size() == 0)) begin n_fail++; $display("FAIL burst_tlast: got %b want %b", if4.m_udp_payload_axis_tlast, q4.size() == 0); end
                done = (q4.size() == 0);
            end
            prev_stall = if4.m_udp_payload_axis_tvalid && !if4.m_udp_payload_axis_tready;
            pd = if4.m_udp_payload_axis_tdata;
            pl = if4.m_udp_payload_axis_tlast;
            @(negedge clk);
        end
        if4.m_udp_payload_axis_tready = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL burst_timeout: got %0d bytes left want 0", q4.size()); end
        n_checks++; if ({if4.m_udp_payload_axis_tvalid, r4} !== 2'b01) begin n_fail++; $display("FAIL burst_done: got tv/ready %b want 01", {if4.m_udp_payload_axis_tvalid, r4}); end
    endtask

    task automatic test_flush_timeout;
        int k = 0;
        beat(8, 8'h01); beat(8, 8'h02);
        for (int i = 0; i < 14; i++) @(negedge clk);
        n_checks++; if (if8.m_udp_hdr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b want 0", if8.m_udp_hdr_valid); end
        beat(8, 8'h03);
        while (!if8.m_udp_hdr_valid && k < 40) begin
            k++;
            @(negedge clk);
        end
        n_checks++; if (k !== 16) begin n_fail++; $display("FAIL flush_delay: got %0d cycles want 16", k); end
        n_checks++; if (if8.m_udp_length !== 16'd11) begin n_fail++; $display("FAIL flush_length: got %0d want 11", if8.m_udp_length); end
        if8.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if8.m_udp_hdr_ready = 1'b0;
        if8.m_udp_payload_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = (q8.size() > 0) ? q8.pop_front() : 8'hxx;
            n_checks++; if ({if8.m_udp_payload_axis_tvalid, if8.m_udp_payload_axis_tlast, if8.m_udp_payload_axis_tdata} !== {1'b1, 1'(q8.size() == 0), exp}) begin n_fail++; $display("FAIL flush_byte: got tv/tl %b data %h want 1%b %h", {if8.m_udp_payload_axis_tvalid, if8.m_udp_payload_axis_tlast}, if8.m_udp_payload_axis_tdata, q8.size() == 0, exp); end
            @(negedge clk);
        end
        if8.m_udp_payload_axis_tready = 1'b0;
        n_checks++; if ({if8.m_udp_payload_axis_tvalid, r8} !== 2'b01) begin n_fail++; $display("FAIL flush_done: got tv/ready %b want 01", {if8.m_udp_payload_axis_tvalid, r8}); end
    endtask

    task automatic test_hdr_hold;
        beat(4, 8'h5A); beat(4, 8'h6B); beat(4, 8'h7C); beat(4, 8'h8D);
        cmd = 4'hF; dat = 4'hF;
        v4 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            n_checks++; if ({if4.m_udp_hdr_valid, if4.m_udp_length, if4.m_udp_ip_dest_ip, if4.m_udp_dest_port} !== {1'b1, 16'd12, 32'h0A2A0001, 16'd5000}) begin n_fail++; $display("FAIL hold_header: got hv %b len %0d ip %h port %0d want 1 12 0a2a0001 5000", if4.m_udp_hdr_valid, if4.m_udp_length, if4.m_udp_ip_dest_ip, if4.m_udp_dest_port); end
            n_checks++; if (r4 !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b want 0", r4); end
            if (c == 25) begin
                peer_ip   = 32'hC0A80001;
                peer_port = 16'd1234;
            end
            @(negedge clk);
        end
        v4 = 1'b0;
        if4.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if4.m_udp_hdr_ready = 1'b0;
        if4.m_udp_payload_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
            n_checks++; if ({if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast, if4.m_udp_payload_axis_tdata} !== {1'b1, 1'(q4.size() == 0), exp}) begin n_fail++; $display("FAIL hold_byte: got tv/tl %b data %h want 1%b %h", {if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast}, if4.m_udp_payload_axis_tdata, q4.size() == 0, exp); end
            n_checks++; if (if4.m_udp_ip_dest_ip !== 32'h0A2A0001) begin n_fail++; $display("FAIL hold_dest_latched: got %h want 0a2a0001", if4.m_udp_ip_dest_ip); end
            @(negedge clk);
        end
        if4.m_udp_payload_axis_tready = 1'b0;
        peer_ip   = 32'h0A2A0001;
        peer_port = 16'd5000;
        n_checks++; if ({if4.m_udp_payload_axis_tvalid, r4} !== 2'b01) begin n_fail++; $display("FAIL hold_done: got tv/ready %b want 01", {if4.m_udp_payload_axis_tvalid, r4}); end
    endtask

    task automatic test_reset_abort;
        beat(4, 8'h10); beat(4, 8'h20); beat(4, 8'h30); beat(4, 8'h40);
        if4.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if4.m_udp_hdr_ready = 1'b0;
        if4.m_udp_payload_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
            n_checks++; if ({if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tdata} !== {1'b1, exp}) begin n_fail++; $display("FAIL abort_prefix_byte: got tv %b data %h want 1 %h", if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tdata, exp); end
            if (i < 2) @(negedge clk);
        end
        if4.m_udp_payload_axis_tready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({if4.m_udp_payload_axis_tvalid, if4.m_udp_hdr_valid, if4.m_udp_payload_axis_tlast, r4, busy4} !== 5'b00000) begin n_fail++; $display("FAIL abort_reset_values: got tv/hv/tl/ready/busy %b want 00000", {if4.m_udp_payload_axis_tvalid, if4.m_udp_hdr_valid, if4.m_udp_payload_axis_tlast, r4, busy4}); end
        rst = 1'b0;
        q4.delete();
        #1;
        n_checks++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", r4); end
        beat(4, 8'hC1); beat(4, 8'hC2); beat(4, 8'hC3);
        n_checks++; if (if4.m_udp_hdr_valid !== 1'b0) begin n_fail++; $display("FAIL abort_cnt_cleared: got hv %b after 3 beats want 0", if4.m_udp_hdr_valid); end
        beat(4, 8'hC4);
        n_checks++; if ({if4.m_udp_hdr_valid, if4.m_udp_length} !== {1'b1, 16'd12}) begin n_fail++; $display("FAIL abort_fresh_header: got hv %b len %0d want 1 12", if4.m_udp_hdr_valid, if4.m_udp_length); end
        if4.m_udp_hdr_ready = 1'b1;
        @(negedge clk);
        if4.m_udp_hdr_ready = 1'b0;
        if4.m_udp_payload_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
            n_checks++; if ({if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast, if4.m_udp_payload_axis_tdata} !== {1'b1, 1'(q4.size() == 0), exp}) begin n_fail++; $display("FAIL abort_fresh_byte: got tv/tl %b data %h want 1%b %h", {if4.m_udp_payload_axis_tvalid, if4.m_udp_payload_axis_tlast}, if4.m_udp_payload_axis_tdata, q4.size() == 0, exp); end
            @(negedge clk);
        end
        if4.m_udp_payload_axis_tready = 1'b0;
        n_checks++; if ({if4.m_udp_payload_axis_tvalid, r4} !== 2'b01) begin n_fail++; $display("FAIL abort_fresh_done: got tv/ready %b want 01", {if4.m_udp_payload_axis_tvalid, r4}); end
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        cmd = '0; dat = '0;
        peer_valid = 1'b1;
        peer_ip    = 32'h0A2A0001;
        peer_port  = 16'd5000;
        local_ip   = 32'h0A2A00A4;
        local_port = 16'd8887;
        if1.m_udp_hdr_ready = 1'b0; if1.m_udp_payload_axis_tready = 1'b0;
        if4.m_udp_hdr_ready = 1'b0; if4.m_udp_payload_axis_tready = 1'b0;
        if8.m_udp_hdr_ready = 1'b0; if8.m_udp_payload_axis_tready = 1'b0;
        test_reset();
        test_single_byte();
        test_no_peer();
        test_random_tready();
        test_flush_timeout();
        test_hdr_hold();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
